// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read-side companion to the synchronous fifo. Pops words from the FIFO read
//   port and re-presents them on a valid/ready stream. A 2-entry output buffer
//   hides the FIFO's one-cycle read latency, so the consumer sees show-ahead
//   data at up to one word per cycle.
//
//   Optional build macro: FIFO_STREAM_READER_STATS_EN adds transfer and stall
//   counters (xfer_count, stall_count).
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   fifo_empty    FIFO empty flag
//   fifo_rd_data  FIFO data_out, valid the cycle after an accepted read
//   fifo_rd_en    FIFO read enable
//   m_valid       stream word valid
//   m_data        stream word (head of output buffer)
//   m_ready       downstream accepts word
//   flush         synchronous discard of buffered and in-flight data
//   xfer_count    (stats build) completed transfers, wraps
//   stall_count   (stats build) cycles with m_valid && !m_ready, saturates
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  flush
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [31:0]           xfer_count,
  output logic [31:0]           stall_count
`endif
);

  logic [DATA_WIDTH-1:0] head_q, tail_q;
  logic [DATA_WIDTH-1:0] head_n, tail_n;
  logic [1:0]            count_q, count_n, count_after_pop;
  logic                  inflight_q;
  logic                  pop;
  logic [2:0]            committed;

  assign m_valid = (count_q != 2'd0);
  assign m_data  = head_q;
  assign pop     = m_valid & m_ready;

  // Slots that will still be occupied or reserved after this cycle's pop.
  // A read is issued only if its word is guaranteed a free slot on arrival.
  assign committed  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en = !fifo_empty && !flush && !rst && (committed < 3'd2);

  assign count_after_pop = count_q - {1'b0, pop};

  always_comb begin
    head_n  = head_q;
    tail_n  = tail_q;
    count_n = count_after_pop + {1'b0, inflight_q};
    if (pop) head_n = tail_q;
    // Arriving word lands directly behind whatever survives the pop.
    if (inflight_q) begin
      if (count_after_pop == 2'd0) head_n = fifo_rd_data;
      else                         tail_n = fifo_rd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
    end else if (flush) begin
      // In-flight data is dropped by clearing inflight; buffer contents are
      // left as-is since count=0 already hides them.
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      head_q     <= head_n;
      tail_q     <= tail_n;
      count_q    <= count_n;
      inflight_q <= fifo_rd_en;
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count  <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (pop) xfer_count <= xfer_count + 32'd1;
      if (m_valid && !m_ready && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_en;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
  logic       flush = 1'b0;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] xfer_count, stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fifo_stream_reader #(.DATA_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .flush        (flush)
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    .xfer_count   (xfer_count),
    .stall_count  (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural synchronous FIFO: registered empty flag, one-cycle read latency.
  logic [7:0] mem[$];
  logic [7:0] pend[$];

  always @(posedge clk) begin
    if (rst) begin
      mem.delete();
      fifo_empty   <= 1'b1;
      fifo_rd_data <= 8'h00;
    end else begin
      if (fifo_rd_en && mem.size() != 0) fifo_rd_data <= mem.pop_front();
      while (pend.size() != 0) mem.push_back(pend.pop_front());
      fifo_empty <= (mem.size() == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic restart(input bit preload);
    @(negedge clk);
    rst = 1'b1;
    m_ready = 1'b0;
    flush = 1'b0;
    pend.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    if (preload) begin
      pend.push_back(8'h11);
      pend.push_back(8'h22);
      pend.push_back(8'h33);
      pend.push_back(8'h44);
    end
  endtask

  typedef struct {
    bit         restart;
    bit         ready;
    bit         flush;
    bit         exp_rd;
    bit         exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [7:0] exp_q[$];
    int         sent, recv, stalls, pops;
    bit         prev_stall;
    logic [7:0] prev_data;
    bit         seen;

    // Streaming with m_ready=1 (first row restarts with 4 words preloaded).
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h44});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    // Backpressure: two reads then stop, then drain without gaps.
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h44});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});

    // Idle after reset with empty FIFO.
    restart(1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("idle_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      chk("idle_valid", {31'd0, m_valid}, 32'd0);
      chk("idle_data", {24'd0, m_data}, 32'd0);
    end

    foreach (tbl[i]) begin
      if (tbl[i].restart) restart(1'b1);
      @(negedge clk);
      m_ready = tbl[i].ready;
      flush   = tbl[i].flush;
      #1;
      chk($sformatf("vec%0d_rd_en", i), {31'd0, fifo_rd_en}, {31'd0, tbl[i].exp_rd});
      chk($sformatf("vec%0d_valid", i), {31'd0, m_valid}, {31'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid)
        chk($sformatf("vec%0d_data", i), {24'd0, m_data}, {24'd0, tbl[i].exp_data});
    end

    // Flush one cycle after a read issue with one word buffered.
    restart(1'b0);
    pend.push_back(8'hA1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("fl_pre_valid", {31'd0, m_valid}, 32'd1);
    chk("fl_pre_data", {24'd0, m_data}, 32'hA1);
    pend.push_back(8'hB2);
    @(negedge clk);
    #1;
    chk("fl_issue_rd", {31'd0, fifo_rd_en}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    pend.push_back(8'hC3);
    #1;
    chk("fl_rd_en_low", {31'd0, fifo_rd_en}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("fl_valid_low", {31'd0, m_valid}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (m_valid) seen = 1'b1;
    end
    chk("fl_next_seen", {31'd0, seen}, 32'd1);
    chk("fl_next_data", {24'd0, m_data}, 32'hC3);

    // Random traffic against an in-order scoreboard.
    restart(1'b0);
    sent = 0;
    recv = 0;
    prev_stall = 1'b0;
    prev_data = 8'h00;
    for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
      logic [7:0] b;
      @(negedge clk);
      m_ready = ($urandom_range(0, 1) == 1);
      if (sent < 1000 && (mem.size() + pend.size()) < 4 && $urandom_range(0, 3) != 0) begin
        b = 8'($urandom);
        pend.push_back(b);
        exp_q.push_back(b);
        sent++;
      end
      #1;
      if (fifo_rd_en && fifo_empty) chk("rnd_rd_when_empty", 32'd1, 32'd0);
      if (prev_stall) begin
        chk("rnd_hold_valid", {31'd0, m_valid}, 32'd1);
        chk("rnd_hold_data", {24'd0, m_data}, {24'd0, prev_data});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("rnd_extra_word", {24'd0, m_data}, 32'hFFFF_FFFF);
        else chk("rnd_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        recv++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
    chk("rnd_recv_count", recv, 32'd1000);
    chk("rnd_scoreboard_left", exp_q.size(), 32'd0);

`ifdef FIFO_STREAM_READER_STATS_EN
    restart(1'b1);
    stalls = 0;
    for (int i = 0; i < 20 && stalls < 3; i++) begin
      @(negedge clk);
      m_ready = 1'b0;
      #1;
      if (m_valid) stalls++;
    end
    pops = 0;
    for (int i = 0; i < 20 && pops < 4; i++) begin
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      if (m_valid) pops++;
    end
    @(negedge clk);
    m_ready = 1'b0;
    #1;
    chk("st_xfer", xfer_count, 32'd4);
    chk("st_stall", stall_count, 32'd3);
`endif

    // Async reset with two words buffered.
    restart(1'b1);
    for (int i = 0; i < 4; i++) @(negedge clk);
    #1;
    chk("rst_pre_valid", {31'd0, m_valid}, 32'd1);
    chk("rst_pre_data", {24'd0, m_data}, 32'h11);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data", {24'd0, m_data}, 32'd0);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
`ifdef FIFO_STREAM_READER_STATS_EN
    chk("rst_xfer", xfer_count, 32'd0);
    chk("rst_stall", stall_count, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side companion to the team's synchronous `fifo`.
- Drives the FIFO read port (`rd_en` / `data_out` / `empty`) and re-presents the popped words on a valid/ready stream.
- Hides the FIFO's one-cycle read latency behind a 2-entry output buffer, so downstream consumers get show-ahead data at up to one word per cycle.
- Sits between any `fifo` instance and a downstream valid/ready consumer.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and stream data.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO `empty` flag.
- fifo_rd_data  input  DATA_WIDTH  FIFO `data_out`; valid the cycle after an accepted read.
- fifo_rd_en  output  1  FIFO read enable.
- m_valid  output  1  stream word valid.
- m_data  output  DATA_WIDTH  stream word; head of the output buffer.
- m_ready  input  1  downstream accepts word.
- flush  input  1  synchronous discard of buffered and in-flight data.

Behaviour:
- Reset (async, rst=1):
  - buffer count = 0, inflight = 0.
  - m_valid = 0, m_data = 0, fifo_rd_en = 0.
  - All buffer entries cleared.
- State:
  - 2-entry ordered buffer (head, tail), count 0..2.
  - inflight bit = a read was issued last cycle and its data arrives this cycle.
- pop = m_valid && m_ready.
- m_valid = (count != 0). m_data = head entry. Both come only from registers.
- fifo_rd_en = !fifo_empty && !flush && !rst && (count + inflight - pop < 2).
  - This is the only combinational path from m_ready.
- Read latency:
  - fifo_rd_en high in cycle N sets inflight for cycle N+1.
  - fifo_rd_data is captured at the end of cycle N+1 into slot [count - pop].
  - The word is visible on m_data from cycle N+2.
  - First-word latency from fifo_empty falling with the buffer idle: 2 cycles.
- Throughput:
  - With m_ready held high and the FIFO non-empty, one word per cycle after the first 2-cycle latency.
  - No bubbles.
- Ordering: words leave in exactly the order they were read from the FIFO. No duplication, no loss.
- Simultaneous pop and capture in one cycle:
  - Head shifts out, tail moves to head, new word lands behind it.
  - Count is unchanged.
- Backpressure:
  - m_ready low keeps m_valid high and m_data stable.
  - Reads stop once count + inflight reaches 2.
  - The buffer never overflows.
- fifo_empty:
  - Sampled only in the cycle fifo_rd_en would assert.
  - No read is issued while fifo_empty=1, even if space is free.
- flush=1 for one cycle:
  - Next cycle: count = 0, inflight = 0, m_valid = 0.
  - Data arriving from an in-flight read is dropped.
  - fifo_rd_en = 0 during flush.
  - A pop in the flush cycle still counts as a completed transfer.
- Reset mid-transfer: state clears immediately. An in-flight FIFO word is lost; this is acceptable and the system resets the FIFO together with this block.

Optional Feature:
- Macro: FIFO_STREAM_READER_STATS_EN.
- Defined — adds two outputs:
  - xfer_count (32-bit): increments on each pop; wraps 0xFFFFFFFF→0.
  - stall_count (32-bit): increments each cycle with m_valid=1 and m_ready=0; saturates at 0xFFFFFFFF.
  - Both reset to 0; flush does not clear them.
- Undefined: ports and counters absent; datapath behaviour identical.

Test Plan:
- Reset, fifo_empty=1 for 10 cycles -> fifo_rd_en=0, m_valid=0, m_data=0 throughout.
- FIFO (DEPTH=4) preloaded with 0x11, 0x22, 0x33, 0x44, m_ready=1 -> m_valid rises 2 cycles after the first fifo_rd_en; words appear on consecutive cycles in that order; fifo_rd_en falls when fifo_empty=1; m_valid falls after 0x44.
- Same load, m_ready=0 -> exactly 2 reads issued; m_data holds 0x11. Then m_ready=1 -> 0x11, 0x22, 0x33, 0x44 with no gaps and no duplicates.
- Random m_ready (50%), 1000 random bytes pushed through the FIFO -> scoreboard queue matches every popped word; fifo_rd_en never asserted while fifo_empty=1.
- flush asserted the cycle after a read issue, with count=1 -> m_valid=0 next cycle; the in-flight word is never output; the next output is the following FIFO word.
- rst pulsed while m_valid=1 with count=2 -> outputs zero asynchronously. With STATS_EN: after 4 pops and 3 stall cycles, xfer_count=4 and stall_count=3.
